// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Groups the signals exchanged between the hazard sequencer and the
// fetch/decode/execute datapath plus the multdiv handshake.
//
//   master : the hazard controller itself
//            inputs  fd_insn, dx_insn, dx_redirect, md_ready
//            outputs pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop,
//                    md_start, md_done, md_error
//   slave  : the pipeline / multdiv side (mirror image of master)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [31:0] fd_insn;
  logic [31:0] dx_insn;
  logic        dx_redirect;
  logic        md_ready;
  logic        pc_en;
  logic        fd_en;
  logic        dx_en;
  logic        fd_flush;
  logic        dx_nop;
  logic        xm_nop;
  logic        md_start;
  logic        md_done;
  logic        md_error;

  modport master (
    input  fd_insn,
    input  dx_insn,
    input  dx_redirect,
    input  md_ready,
    output pc_en,
    output fd_en,
    output dx_en,
    output fd_flush,
    output dx_nop,
    output xm_nop,
    output md_start,
    output md_done,
    output md_error
  );

  modport slave (
    output fd_insn,
    output dx_insn,
    output dx_redirect,
    output md_ready,
    input  pc_en,
    input  fd_en,
    input  dx_en,
    input  fd_flush,
    input  dx_nop,
    input  xm_nop,
    input  md_start,
    input  md_done,
    input  md_error
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard sequencer for the 5-stage core. Every cycle it decides
// whether PC, F/D and D/X advance, hold, or load a bubble:
//   - load-use stall (lw in D/X feeding the instruction in F/D): 1 cycle
//   - multdiv issue and wait on the md_start / md_ready handshake
//   - control-flow flush when execute resolves a taken branch/jump
// It is the only source of the enable and flush/nop controls between fetch
// and execute.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low
//   hz (master)    fd_insn, dx_insn, dx_redirect, md_ready in;
//                  pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop,
//                  md_start, md_done, md_error out
//   stall_cycles   (HAZARD_PERF_CNT_EN only) cycles with pc_en = 0
//   flush_count    (HAZARD_PERF_CNT_EN only) cycles with fd_flush = 1
//
// Parameter:
//   MD_TIMEOUT     MD_WAIT cycles without md_ready before md_error sets
//                  (legal range 2..255)
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds the two perf counters).
//
// All control outputs are Mealy: combinational from state and the current
// inputs, so the stall decision has zero latency. md_error is a flop.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 32'd40
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MD_ISSUE = 2'b01,
    ST_MD_WAIT  = 2'b10
  } state_e;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Counter value seen on the MD_TIMEOUT-th MD_WAIT cycle (counter starts at 0).
  localparam logic [7:0] TIMEOUT_LAST = 8'(MD_TIMEOUT - 32'd1);

  // ---------------------------------------------------------------------------
  // Instruction field helpers
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] f_opcode(input logic [31:0] insn);
    return insn[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] insn);
    return insn[26:22];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] insn);
    return insn[21:17];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] insn);
    return insn[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] insn);
    return insn[6:2];
  endfunction

  function automatic logic f_is_multdiv(input logic [31:0] insn);
    logic res;
    res = 1'b0;
    if (f_opcode(insn) == OP_ALU) begin
      if ((f_aluop(insn) == ALU_MUL) || (f_aluop(insn) == ALU_DIV)) begin
        res = 1'b1;
      end else begin
        res = 1'b0;
      end
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  // lw in D/X whose destination is read by the F/D instruction. Stores and
  // branches/jr carry a source operand in the rd field, so rd is compared for
  // those opcodes; rs2 is only a register for R-type ALU instructions.
  function automatic logic f_load_use(input logic [31:0] fd, input logic [31:0] dx);
    logic [4:0] dst;
    logic       hit;
    dst = f_rd(dx);
    hit = (dst == f_rs1(fd));
    if ((f_opcode(fd) == OP_ALU) && (dst == f_rs2(fd))) begin
      hit = 1'b1;
    end else begin
      hit = hit;
    end
    case (f_opcode(fd))
      OP_SW, OP_BNE, OP_BLT, OP_JR: begin
        if (dst == f_rd(fd)) begin
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end
      default: hit = hit;
    endcase
    return (f_opcode(dx) == OP_LW) && (dst != 5'd0) && hit;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  state_e     state_eff_s;
  logic [7:0] cnt_q, cnt_d;
  logic       error_q, error_d;
  logic       load_use_s;
  logic       md_insn_s;
  logic       timeout_s;
  logic       unused_insn_bits_s;

  // Field bits the sequencer never looks at.
  assign unused_insn_bits_s = ^{hz.fd_insn[11:0], hz.dx_insn[21:7], hz.dx_insn[1:0]};

  // Hazard decode from the two latched instruction words.
  always_comb begin
    load_use_s = f_load_use(hz.fd_insn, hz.dx_insn);
    md_insn_s  = f_is_multdiv(hz.dx_insn);
    timeout_s  = (cnt_q == TIMEOUT_LAST);
  end

  // While reset is held the outputs already follow RUN so an abandoned
  // multdiv wait can never produce md_done.
  always_comb begin
    if (reset) begin
      state_eff_s = state_q;
    end else begin
      state_eff_s = ST_RUN;
    end
  end

  // Next-state and Mealy output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    hz.pc_en    = 1'b1;
    hz.fd_en    = 1'b1;
    hz.dx_en    = 1'b1;
    hz.fd_flush = 1'b0;
    hz.dx_nop   = 1'b0;
    hz.xm_nop   = 1'b0;
    hz.md_start = 1'b0;
    hz.md_done  = 1'b0;
    case (state_eff_s)
      ST_RUN: begin
        if (hz.dx_redirect) begin
          hz.fd_flush = 1'b1;
          hz.dx_nop   = 1'b1;
          state_d     = ST_RUN;
        end else if (md_insn_s) begin
          // Hold the multdiv in D/X while it executes; X/M gets bubbles.
          hz.md_start = 1'b1;
          hz.pc_en    = 1'b0;
          hz.fd_en    = 1'b0;
          hz.dx_en    = 1'b0;
          hz.xm_nop   = 1'b1;
          cnt_d       = 8'd0;
          state_d     = ST_MD_WAIT;
        end else if (load_use_s) begin
          // Bubble into D/X; next cycle the lw has moved on, so this is 1 cycle.
          hz.pc_en  = 1'b0;
          hz.fd_en  = 1'b0;
          hz.dx_nop = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        if (hz.md_ready) begin
          hz.md_done = 1'b1;
          cnt_d      = 8'd0;
          state_d    = ST_RUN;
        end else if (timeout_s) begin
          // Give up: retire the multdiv with whatever the unit drives and
          // advance the pipeline exactly as for a normal completion.
          hz.md_done = 1'b1;
          error_d    = 1'b1;
          cnt_d      = 8'd0;
          state_d    = ST_RUN;
        end else begin
          hz.pc_en  = 1'b0;
          hz.fd_en  = 1'b0;
          hz.dx_en  = 1'b0;
          hz.xm_nop = 1'b1;
          if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
          state_d = ST_MD_WAIT;
        end
      end
      ST_MD_ISSUE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, timeout counter and sticky error registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign hz.md_error = error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Performance counter increments; both wrap naturally at 2^32.
  always_comb begin
    if (hz.pc_en) begin
      stall_cycles_d = stall_cycles_q;
    end else begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (hz.fd_flush) begin
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two hazard_ctrl instances (MD_TIMEOUT 40 and 4) receive identical stimulus.
// A behavioural model tracks, per instance, whether a multdiv is outstanding,
// how long it has waited, and the sticky error flag, and derives every cycle's
// expected controls from the pipeline rules. Directed steps cover the listed
// scenarios, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clock;
  logic reset;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

  hazard_ctrl #(.MD_TIMEOUT(40)) dut_a (
    .clock (clock),
    .reset (reset),
    .hz    (ifa.master)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_a),
    .flush_count  (flush_a)
`endif
  );

  hazard_ctrl #(.MD_TIMEOUT(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .hz    (ifb.master)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_b),
    .flush_count  (flush_b)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // model state per instance: 0 -> timeout 40, 1 -> timeout 4
  int  m_tmo  [2] = '{40, 4};
  bit  m_busy [2];
  int  m_wait [2];
  bit  m_err  [2];
  longint m_stall;
  longint m_flush;

  logic [8:0] last_a;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int alu);
    logic [31:0] w;
    w = 32'd0;
    w[31:27] = 5'(op);
    w[26:22] = 5'(rd);
    w[21:17] = 5'(rs1);
    w[16:12] = 5'(rs2);
    w[6:2]   = 5'(alu);
    return w;
  endfunction

  function automatic bit is_md(input logic [31:0] dx);
    int op, alu;
    op  = int'(dx[31:27]);
    alu = int'(dx[6:2]);
    return (op == 0) && (alu == 6 || alu == 7);
  endfunction

  function automatic bit is_lu(input logic [31:0] fd, input logic [31:0] dx);
    int dop, drd, fop, frd, frs1, frs2;
    bit uses;
    dop = int'(dx[31:27]); drd = int'(dx[26:22]);
    fop = int'(fd[31:27]); frd = int'(fd[26:22]);
    frs1 = int'(fd[21:17]); frs2 = int'(fd[16:12]);
    uses = (frs1 == drd) || (fop == 0 && frs2 == drd) ||
           ((fop == 7 || fop == 2 || fop == 6 || fop == 4) && frd == drd);
    return (dop == 8) && (drd != 0) && uses;
  endfunction

  // Expected {pc_en,fd_en,dx_en,fd_flush,dx_nop,xm_nop,md_start,md_done,md_error}
  function automatic logic [8:0] model_out(input int k, input bit rst_n,
                                           input logic [31:0] fd, input logic [31:0] dx,
                                           input bit redir, input bit rdy);
    bit pc = 1, fe = 1, de = 1, fl = 0, dn = 0, xn = 0, ms = 0, md = 0;
    if (!m_busy[k] || !rst_n) begin
      if (redir) begin
        fl = 1; dn = 1;
      end else if (is_md(dx)) begin
        ms = 1; pc = 0; fe = 0; de = 0; xn = 1;
      end else if (is_lu(fd, dx)) begin
        pc = 0; fe = 0; dn = 1;
      end
    end else begin
      if (rdy || (m_wait[k] + 1 >= m_tmo[k])) begin
        md = 1;
      end else begin
        pc = 0; fe = 0; de = 0; xn = 1;
      end
    end
    return {pc, fe, de, fl, dn, xn, ms, md, m_err[k]};
  endfunction

  task automatic model_step(input int k, input bit rst_n, input logic [31:0] dx,
                            input bit redir, input bit rdy);
    if (!rst_n) begin
      m_busy[k] = 0; m_wait[k] = 0; m_err[k] = 0;
    end else if (!m_busy[k]) begin
      if (!redir && is_md(dx)) begin
        m_busy[k] = 1; m_wait[k] = 0;
      end
    end else if (rdy) begin
      m_busy[k] = 0;
    end else begin
      m_wait[k] = m_wait[k] + 1;
      if (m_wait[k] >= m_tmo[k]) begin
        m_err[k] = 1; m_busy[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cyc(input logic [31:0] fd, input logic [31:0] dx,
                     input bit redir, input bit rdy, input bit rst_n);
    logic [8:0] ea, eb, oa, ob;
    ifa.fd_insn = fd; ifa.dx_insn = dx; ifa.dx_redirect = redir; ifa.md_ready = rdy;
    ifb.fd_insn = fd; ifb.dx_insn = dx; ifb.dx_redirect = redir; ifb.md_ready = rdy;
    reset = rst_n;
    #4;
    ea = model_out(0, rst_n, fd, dx, redir, rdy);
    eb = model_out(1, rst_n, fd, dx, redir, rdy);
    oa = {ifa.pc_en, ifa.fd_en, ifa.dx_en, ifa.fd_flush, ifa.dx_nop,
          ifa.xm_nop, ifa.md_start, ifa.md_done, ifa.md_error};
    ob = {ifb.pc_en, ifb.fd_en, ifb.dx_en, ifb.fd_flush, ifb.dx_nop,
          ifb.xm_nop, ifb.md_start, ifb.md_done, ifb.md_error};
    last_a = oa;
    chk("ctrl_t40", 32'(oa), 32'(ea));
    chk("ctrl_t4", 32'(ob), 32'(eb));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_a, 32'(m_stall));
    chk("flush_count", flush_a, 32'(m_flush));
`endif
    @(posedge clock);
    if (!rst_n) begin
      m_stall = 0; m_flush = 0;
    end else begin
      m_stall = m_stall + (ea[8] ? 0 : 1);
      m_flush = m_flush + (ea[5] ? 1 : 0);
    end
    model_step(0, rst_n, dx, redir, rdy);
    model_step(1, rst_n, dx, redir, rdy);
    #1;
  endtask

  function automatic logic [31:0] rnd_insn();
    int ops[9] = '{0, 0, 8, 8, 7, 2, 6, 4, 5};
    int alus[4] = '{0, 6, 7, 1};
    return mk(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), alus[$urandom_range(0, 3)]);
  endfunction

  initial begin
    logic [31:0] nop, lw5, add5, lw0, add0, lw7, sw7, addi7, mul;
    int starts, stalls, dones;
    nop   = 32'd0;
    lw5   = mk(8, 5, 1, 0, 0);
    add5  = mk(0, 1, 5, 2, 0);
    lw0   = mk(8, 0, 1, 0, 0);
    add0  = mk(0, 3, 0, 2, 0);
    lw7   = mk(8, 7, 1, 0, 0);
    sw7   = mk(7, 7, 2, 0, 0);
    addi7 = mk(5, 3, 2, 7, 0);
    mul   = mk(0, 4, 1, 2, 6);
    m_stall = 0; m_flush = 0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_wait[k] = 0; m_err[k] = 0;
    end

    @(posedge clock);
    #1;
    // reset
    for (int i = 0; i < 3; i++) cyc(nop, nop, 0, 0, 0);
    chk("reset_idle", 32'(last_a), 32'h1C0);
    cyc(nop, nop, 0, 0, 1);

    // load-use stall for one cycle, then the bubble clears it
    cyc(add5, lw5, 0, 0, 1);
    chk("lu_stall", 32'({last_a[8], last_a[7], last_a[4]}), 32'b001);
    cyc(add5, nop, 0, 0, 1);
    chk("lu_release", 32'(last_a[8:6]), 32'b111);

    // rd=0 no stall; sw rd match stalls; addi rs2 field does not
    cyc(add0, lw0, 0, 0, 1);
    chk("lu_rd0", 32'(last_a[8]), 32'd1);
    cyc(sw7, lw7, 0, 0, 1);
    chk("lu_sw", 32'(last_a[8]), 32'd0);
    cyc(addi7, lw7, 0, 0, 1);
    chk("lu_addi_rs2", 32'(last_a[8]), 32'd1);

    // mul: 17 MD_WAIT cycles without ready, ready on the next
    starts = 0; stalls = 0; dones = 0;
    for (int i = 0; i < 19; i++) begin
      cyc(nop, mul, 0, (i == 18), 1);
      starts += int'(last_a[2]); dones += int'(last_a[1]); stalls += int'(!last_a[8]);
    end
    cyc(nop, nop, 0, 0, 1);
    starts += int'(last_a[2]); dones += int'(last_a[1]); stalls += int'(!last_a[8]);
    chk("mul_starts", 32'(starts), 32'd1);
    chk("mul_dones", 32'(dones), 32'd1);
    chk("mul_stalls", 32'(stalls), 32'd18);

    // redirect beats a load-use hazard
    cyc(add5, lw5, 1, 0, 1);
    chk("redir_lu", 32'({last_a[8], last_a[5], last_a[4]}), 32'b111);

    // back-to-back multdiv with ready on first wait cycle
    cyc(nop, mul, 0, 0, 1);
    cyc(nop, mul, 0, 1, 1);
    cyc(nop, mul, 0, 0, 1);
    cyc(nop, mul, 0, 1, 1);
    cyc(nop, nop, 0, 0, 1);

    // reset abandons MD_WAIT, even with md_ready present
    cyc(nop, mul, 0, 0, 1);
    cyc(nop, nop, 0, 0, 1);
    cyc(nop, nop, 0, 1, 0);
    chk("rst_no_done", 32'(last_a[1]), 32'd0);
    cyc(nop, nop, 0, 1, 1);
    chk("rst_run", 32'(last_a[1]), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(rnd_insn(), rnd_insn(), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) != 0));
    end

    // long wait forcing the 40-cycle timeout, then reset clears md_error
    cyc(nop, mul, 0, 0, 1);
    for (int i = 0; i < 45; i++) cyc(nop, nop, 0, 0, 1);
    chk("t40_error", 32'(last_a[0]), 32'd1);
    cyc(nop, nop, 0, 0, 0);
    cyc(nop, nop, 0, 0, 1);
    chk("t40_cleared", 32'(last_a[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
